// File: rtl/loader_sync_fifo_pkg.sv
// Shared types and defaults for the ioctl-to-SDRAM loader FIFO bridge.
package loader_pkg;

    localparam int LOADER_AW    = 25;
    localparam int LOADER_DEPTH = 8;
    localparam int PTR_W        = $clog2(LOADER_DEPTH);

    typedef struct packed {
        logic [LOADER_AW-1:0] addr;
        logic [7:0]           data;
    } loader_entry_t;

endpackage

// File: rtl/loader_sync_fifo_if.sv
// ioctl download port plus the loader write path and status, as seen by the bridge.
interface loader_sync_fifo_if
    import loader_pkg::*;
#(
    parameter int AW    = LOADER_AW,
    parameter int DEPTH = LOADER_DEPTH
) ();

    logic                     ioctl_download;
    logic                     ioctl_wr;
    logic [AW-1:0]            ioctl_addr;
    logic [7:0]               ioctl_dout;
    logic                     mem_sync;
    logic                     loader_we;
    logic [AW-1:0]            loader_addr;
    logic [7:0]               loader_data;
    logic                     loader_active;
    logic                     overflow;
    logic [$clog2(DEPTH):0]   level;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, mem_sync,
        input  loader_we, loader_addr, loader_data, loader_active, overflow, level
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, mem_sync,
        output loader_we, loader_addr, loader_data, loader_active, overflow, level
    );

endinterface

// File: rtl/loader_sync_fifo_sync_fifo.sv
// Generic single-clock FIFO; head is visible on dout_o whenever empty_o is low.
module sync_fifo
    import loader_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = LOADER_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int IW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IW:0]      wr_ptr_q, wr_ptr_d;
    logic [IW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[IW] != rd_ptr_q[IW]) &&
                     (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign dout_o  = mem_q[rd_ptr_q[IW-1:0]];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[IW-1:0]] <= din_i;
    end

endmodule

// File: rtl/loader_sync_fifo.sv
// Queues ioctl byte writes and replays one SDRAM write per mem_sync slot; keeps
// loader_active high until the queue has drained and the last write was presented.
module loader_sync_fifo
    import loader_pkg::*;
#(
    parameter int            AW          = LOADER_AW,
    parameter int            DEPTH       = LOADER_DEPTH,
    parameter logic [AW-1:0] ADDR_OFFSET = '0
) (
    input  logic                clk_32m,
    input  logic                reset,
    loader_sync_fifo_if.slave   bus
);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } entry_t;

    entry_t        push_entry;
    entry_t        head;
    logic          full;
    logic          empty;
    logic          pop;
    logic          drop;

    logic          we_q,   we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          ovf_q,  ovf_d;
    logic          dl_q;

    // Offset add wraps naturally at AW bits.
    assign push_entry.addr = bus.ioctl_addr + ADDR_OFFSET;
    assign push_entry.data = bus.ioctl_dout;

    assign pop  = bus.mem_sync && !empty;
    assign drop = bus.ioctl_wr && full && !pop;

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk_32m),
        .reset   (reset),
        .push_i  (bus.ioctl_wr),
        .pop_i   (pop),
        .din_i   (push_entry),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (bus.level)
    );

    always_comb begin
        we_d   = we_q;
        addr_d = addr_q;
        data_d = data_q;
        ovf_d  = ovf_q;
        if (bus.mem_sync) begin
            we_d = !empty;
            if (!empty) begin
                addr_d = head.addr;
                data_d = head.data;
            end
        end
        // A drop coinciding with a new download still gets flagged.
        if (bus.ioctl_download && !dl_q) ovf_d = 1'b0;
        if (drop)                        ovf_d = 1'b1;
    end

    always_ff @(posedge clk_32m) begin
        if (reset) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            ovf_q  <= 1'b0;
            dl_q   <= 1'b0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            ovf_q  <= ovf_d;
            dl_q   <= bus.ioctl_download;
        end
    end

    assign bus.loader_we     = we_q;
    assign bus.loader_addr   = addr_q;
    assign bus.loader_data   = data_q;
    assign bus.overflow      = ovf_q;
    assign bus.loader_active = bus.ioctl_download || !empty || we_q;

endmodule

// File: tb/tb_loader_sync_fifo.sv
// Directed bench for loader_sync_fifo: two instances differing only in ADDR_OFFSET.
module tb_loader_sync_fifo;
    import loader_pkg::*;

    localparam int AW    = 25;
    localparam int DEPTH = 8;

    logic clk_32m = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_32m = ~clk_32m;

    loader_sync_fifo_if #(.AW(AW), .DEPTH(DEPTH)) if_a ();
    loader_sync_fifo_if #(.AW(AW), .DEPTH(DEPTH)) if_b ();

    assign if_b.ioctl_download = if_a.ioctl_download;
    assign if_b.ioctl_wr       = if_a.ioctl_wr;
    assign if_b.ioctl_addr     = if_a.ioctl_addr;
    assign if_b.ioctl_dout     = if_a.ioctl_dout;
    assign if_b.mem_sync       = if_a.mem_sync;

    loader_sync_fifo #(.AW(AW), .DEPTH(DEPTH), .ADDR_OFFSET(25'h0028000)) dut_a (
        .clk_32m (clk_32m),
        .reset   (reset),
        .bus     (if_a.slave)
    );

    loader_sync_fifo #(.AW(AW), .DEPTH(DEPTH), .ADDR_OFFSET(25'h0000002)) dut_b (
        .clk_32m (clk_32m),
        .reset   (reset),
        .bus     (if_b.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_32m);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] addr, input logic [7:0] data);
        if_a.ioctl_wr   = 1'b1;
        if_a.ioctl_addr = addr;
        if_a.ioctl_dout = data;
        step();
        if_a.ioctl_wr   = 1'b0;
    endtask

    // period-1 idle cycles followed by one mem_sync cycle
    task automatic slot(input int period);
        if_a.mem_sync = 1'b0;
        repeat (period - 1) step();
        if_a.mem_sync = 1'b1;
        step();
        if_a.mem_sync = 1'b0;
    endtask

    initial begin
        if_a.ioctl_download = 1'b0;
        if_a.ioctl_wr       = 1'b0;
        if_a.ioctl_addr     = '0;
        if_a.ioctl_dout     = '0;
        if_a.mem_sync       = 1'b0;
        reset               = 1'b1;
        repeat (2) step();

        // Reset state
        check_eq("rst_we",     if_a.loader_we,     0);
        check_eq("rst_addr",   if_a.loader_addr,   0);
        check_eq("rst_data",   if_a.loader_data,   0);
        check_eq("rst_ovf",    if_a.overflow,      0);
        check_eq("rst_level",  if_a.level,         0);
        check_eq("rst_active", if_a.loader_active, 0);
        reset = 1'b0;
        step();

        // Single byte with a 32-cycle slot period
        if_a.ioctl_download = 1'b1;
        push(25'h10, 8'hA5);
        check_eq("single_level",  if_a.level,         1);
        check_eq("single_active", if_a.loader_active, 1);
        check_eq("single_we_pre", if_a.loader_we,     0);
        slot(32);
        check_eq("single_we",     if_a.loader_we,     1);
        check_eq("single_addr",   if_a.loader_addr,   32'h28010);
        check_eq("single_data",   if_a.loader_data,   32'hA5);
        check_eq("single_lvl0",   if_a.level,         0);
        if_a.ioctl_download = 1'b0;
        step();
        check_eq("single_act_hold", if_a.loader_active, 1);
        check_eq("single_we_hold",  if_a.loader_we,     1);
        slot(31);
        check_eq("single_we_off",   if_a.loader_we,     0);
        check_eq("single_addr_hold", if_a.loader_addr,  32'h28010);
        check_eq("single_act_off",  if_a.loader_active, 0);

        // Burst of 8 within depth
        if_a.ioctl_download = 1'b1;
        for (int i = 0; i < 8; i++) push(25'h100 + 25'(i), 8'h30 + 8'(i));
        check_eq("burst_level", if_a.level,    8);
        check_eq("burst_ovf",   if_a.overflow, 0);
        for (int i = 0; i < 8; i++) begin
            slot(4);
            check_eq($sformatf("burst_we%0d", i),   if_a.loader_we,   1);
            check_eq($sformatf("burst_addr%0d", i), if_a.loader_addr, 32'h28100 + i);
            check_eq($sformatf("burst_data%0d", i), if_a.loader_data, 32'h30 + i);
        end
        slot(4);
        check_eq("burst_we_off", if_a.loader_we, 0);
        if_a.ioctl_download = 1'b0;
        step();

        // Overflow: 10 pushes, no slots
        if_a.ioctl_download = 1'b1;
        for (int i = 0; i < 10; i++) push(25'h200 + 25'(i), 8'h50 + 8'(i));
        check_eq("ovf_level", if_a.level,    8);
        check_eq("ovf_flag",  if_a.overflow, 1);
        for (int i = 0; i < 8; i++) begin
            slot(4);
            check_eq($sformatf("ovf_data%0d", i), if_a.loader_data, 32'h50 + i);
        end
        slot(4);
        check_eq("ovf_we_off",    if_a.loader_we,   0);
        check_eq("ovf_data_hold", if_a.loader_data, 32'h57);
        check_eq("ovf_addr_hold", if_a.loader_addr, 32'h28207);
        check_eq("ovf_sticky",    if_a.overflow,    1);
        if_a.ioctl_download = 1'b0;
        step();
        if_a.ioctl_download = 1'b1;
        step();
        check_eq("ovf_cleared", if_a.overflow, 0);

        // Push coinciding with mem_sync on an empty FIFO: no bypass
        if_a.ioctl_wr   = 1'b1;
        if_a.ioctl_addr = 25'h300;
        if_a.ioctl_dout = 8'h77;
        if_a.mem_sync   = 1'b1;
        step();
        if_a.ioctl_wr   = 1'b0;
        if_a.mem_sync   = 1'b0;
        check_eq("nobypass_we",    if_a.loader_we, 0);
        check_eq("nobypass_level", if_a.level,     1);
        slot(4);
        check_eq("nobypass_we2",   if_a.loader_we,   1);
        check_eq("nobypass_addr",  if_a.loader_addr, 32'h28300);
        check_eq("nobypass_data",  if_a.loader_data, 32'h77);
        slot(4);

        // Push coinciding with mem_sync on a full FIFO
        for (int i = 0; i < 8; i++) push(25'h400 + 25'(i), 8'h10 + 8'(i));
        check_eq("fullpp_level_pre", if_a.level, 8);
        if_a.ioctl_wr   = 1'b1;
        if_a.ioctl_addr = 25'h408;
        if_a.ioctl_dout = 8'h18;
        if_a.mem_sync   = 1'b1;
        step();
        if_a.ioctl_wr   = 1'b0;
        if_a.mem_sync   = 1'b0;
        check_eq("fullpp_level", if_a.level,       8);
        check_eq("fullpp_we",    if_a.loader_we,   1);
        check_eq("fullpp_data",  if_a.loader_data, 32'h10);
        check_eq("fullpp_ovf",   if_a.overflow,    0);
        for (int i = 1; i < 9; i++) begin
            slot(4);
            check_eq($sformatf("fullpp_data%0d", i), if_a.loader_data, 32'h10 + i);
        end
        slot(4);
        check_eq("fullpp_we_off", if_a.loader_we, 0);

        // Address wrap
        push(25'h1FFFFFF, 8'hC3);
        slot(4);
        check_eq("wrap_addr_b", if_b.loader_addr, 32'h0000001);
        check_eq("wrap_addr_a", if_a.loader_addr, 32'h0027FFF);
        check_eq("wrap_data_b", if_b.loader_data, 32'hC3);
        slot(4);

        // Reset mid-download with 5 entries queued
        for (int i = 0; i < 10; i++) push(25'h600 + 25'(i), 8'h60 + 8'(i));
        repeat (3) slot(4);
        check_eq("midrst_level_pre", if_a.level,    5);
        check_eq("midrst_ovf_pre",   if_a.overflow, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("midrst_level",  if_a.level,         0);
        check_eq("midrst_we",     if_a.loader_we,     0);
        check_eq("midrst_ovf",    if_a.overflow,      0);
        check_eq("midrst_data",   if_a.loader_data,   0);
        check_eq("midrst_active", if_a.loader_active, 1);
        push(25'h500, 8'h99);
        check_eq("midrst_level1", if_a.level, 1);
        slot(4);
        check_eq("midrst_we2",   if_a.loader_we,   1);
        check_eq("midrst_addr2", if_a.loader_addr, 32'h28500);
        check_eq("midrst_data2", if_a.loader_data, 32'h99);
        if_a.ioctl_download = 1'b0;
        step();
        check_eq("midrst_act_hold", if_a.loader_active, 1);
        slot(4);
        check_eq("midrst_we_off",  if_a.loader_we,     0);
        check_eq("midrst_act_off", if_a.loader_active, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/loader_sync_fifo.md
# loader_sync_fifo

Buffered bridge between the data_io download port (ioctl_*) and the SDRAM loader write path. Each ioctl byte write is queued in a parametrised FIFO, then replayed as one SDRAM write per mem_sync slot, so bursts of ioctl writes are never lost. It replaces the single-entry, drop-on-collision loader register in the top level. It sits between DATA_IO and the sdram address/data muxes, and drives loader_active so the core stays in reset until the FIFO has drained.

## Interface
- AW, 25: address width of ioctl_addr and loader_addr.
- DEPTH, 8: FIFO entries; power of two, at least 2.
- ADDR_OFFSET, 0: constant added to every address modulo 2^AW; rebases images into sideways banks.
- clk_32m  in  1  system clock.
- reset  in  1  synchronous, active-high; clock clk_32m.
- ioctl_download  in  1  download in progress.
- ioctl_wr  in  1  one-cycle byte-write strobe.
- ioctl_addr  in  AW  byte address.
- ioctl_dout  in  8  byte data.
- mem_sync  in  1  one-cycle memory-slot strobe from the core.
- loader_we  out  1  SDRAM write request for the current slot.
- loader_addr  out  AW  write address, equal to ioctl_addr + ADDR_OFFSET.
- loader_data  out  8  write data.
- loader_active  out  1  ioctl_download OR FIFO non-empty OR loader_we.
- overflow  out  1  sticky flag: at least one write was dropped.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **Push:** ioctl_wr=1 writes {ioctl_addr+ADDR_OFFSET, ioctl_dout} into the FIFO unless it is full.
- **Dropped push:** if the FIFO is full and no pop occurs in the same cycle, the write is discarded and overflow is set.
- **Push while full with pop:** a push in the same cycle as a pop on a full FIFO is accepted.
- **Slot handling:** on each cycle with mem_sync=1:
  - FIFO non-empty: pop the head into loader_addr/loader_data and set loader_we=1.
  - FIFO empty: set loader_we=0. loader_addr and loader_data hold their previous values.
- **Write duration:** loader_we holds for exactly one mem_sync period, from one mem_sync edge to the next. One byte is written per slot.
- **No bypass:** an entry pushed in the same cycle as mem_sync is not eligible for that slot.
- **overflow clearing:** cleared only by reset or by a rising edge of ioctl_download (a new download). It is not cleared by draining.
- **loader_active:** stays high after ioctl_download falls until the last entry has been presented, i.e. until loader_we returns to 0 at the following mem_sync.
- **Address arithmetic:** wraps modulo 2^AW; no carry out.
- **Pointers:** read/write pointers are $clog2(DEPTH)+1 bits wide, so full and empty are distinguished by the MSB.
- **Reset:** empties the FIFO and zeroes every output: loader_we, loader_addr, loader_data, overflow, level. loader_active then equals ioctl_download.
- **Reset mid-download:** remaining queued bytes are discarded. Following ioctl_wr strobes are accepted normally once reset is low.

## Timing
- All outputs are registered except loader_active. loader_active is the combinational OR of a registered term and the ioctl_download input.
- Push at cycle t:
  - level increments at t+1.
  - The entry is eligible for any mem_sync at cycle t+1 or later.
  - loader_* update on the clock edge ending that mem_sync cycle.
- With the FIFO empty and mem_sync period P, the worst-case latency from ioctl_wr to loader_we=1 is P+1 cycles.
- Sustained rate: at most one byte per mem_sync.
- Overflow occurs only when the ioctl rate exceeds 1/P for more than DEPTH bytes.
- level reflects both push and pop of the same cycle at t+1: net 0 when both occur.

## Structure
- Package loader_pkg:
  - loader_entry_t struct {addr, data}, parametrised through AW.
  - Localparams PTR_W = $clog2(DEPTH).
- Sub-module sync_fifo: generic single-clock FIFO with push, pop, full, empty and level. Reusable elsewhere in the codebase.
- The top logic contains only the offset adder, the mem_sync pop/hold register, the overflow flag and the active OR.

## Test plan
- **Single byte:** DEPTH=8, ADDR_OFFSET=0x28000. Push addr 0x10, data 0xA5, with mem_sync every 32 cycles. Required: one slot with loader_we=1, loader_addr=0x28010, loader_data=0xA5, then loader_we=0. loader_active falls at the mem_sync after download ends and the FIFO is empty.
- **Burst within depth:** 8 pushes on consecutive cycles. Required: level reaches 8, overflow stays 0, and 8 consecutive slots write bytes in order with addresses incrementing by 1.
- **Overflow:** 10 back-to-back pushes with no mem_sync. Required: level=8, overflow=1, and the 9th and 10th bytes are never output. A new ioctl_download rising edge clears overflow.
- **Boundary cases:**
  - Push and mem_sync in the same cycle into an empty FIFO: not popped in that slot; output at the next mem_sync.
  - Push and mem_sync on a full FIFO: both succeed and level stays 8.
- **Address wrap:** AW=25, ioctl_addr=0x1FFFFFF, ADDR_OFFSET=2. Required: loader_addr=0x0000001.
- **Reset mid-download:** reset with 5 entries queued. Required: level=0, loader_we=0, overflow=0 on the following cycle. After reset, a push/mem_sync sequence works normally.
